// File: rtl/fetch_pkg.sv
// Shared fetch-unit types and defaults.
// Imported by the PC register and the fetch FSM.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned DEF_STEP     = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: sequential advance, aligned redirect.
// Redirect wins over advance; the increment wraps silently.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP = DEF_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] STEP_V =
    ADDR_W'(STEP);
  // STEP is a power of two, so this clears the low log2(STEP) bits
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~(STEP_V - ADDR_W'(1));

  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_target & ALIGN_MASK;
    end else if (advance) begin
      pc_next = pc + STEP_V;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: IDLE/REQ/HOLD FSM with a one-entry
// instruction hold register in front of the PC register.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned STEP = DEF_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic         take;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .STEP     (STEP),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .reset           (reset),
    .advance         (take),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc)
  );

  assign imem_addr = pc;

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    take       = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          take       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          state_next = en ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A redirect squashes both a same-cycle ack and the held word
    if (redirect_valid) begin
      take       = 1'b0;
      state_next = en ? REQ : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      inst_out <= '0;
      inst_pc  <= RESET_PC;
    end else begin
      state <= state_next;
      if (take) begin
        inst_out <= imem_rdata;
        inst_pc  <= pc;
      end
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the PC and instruction-address width.
REQ-002 Parameter INST_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter STEP, default 4, SHALL set the sequential PC increment; it SHALL be a power of two no greater than 2^(ADDR_W-1).
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-005 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 en  in  1  fetch enable; 1 permits new fetches.
REQ-008 redirect_valid  in  1  branch/jump redirect strobe.
REQ-009 redirect_target  in  ADDR_W  redirect destination PC.
REQ-010 imem_req  out  1  instruction-memory request.
REQ-011 imem_addr  out  ADDR_W  instruction-memory address.
REQ-012 imem_ack  in  1  memory ack; imem_rdata is valid in the same cycle.
REQ-013 imem_rdata  in  INST_W  fetched instruction word.
REQ-014 inst_valid  out  1  a fetched instruction is presented.
REQ-015 inst_ready  in  1  consumer accepts the presented instruction.
REQ-016 inst_out  out  INST_W  presented instruction.
REQ-017 inst_pc  out  ADDR_W  PC of the presented instruction.
REQ-018 pc  out  ADDR_W  next fetch PC, registered.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-020 In IDLE: outputs imem_req=0 and inst_valid=0; if en=1, next state is REQ.
REQ-021 In REQ: outputs imem_req=1 and imem_addr=pc; on imem_ack=1, it captures imem_rdata into inst_out, loads pc into inst_pc, sets pc to pc+STEP, and goes to HOLD.
REQ-022 In REQ, en=0 SHALL NOT abandon an outstanding request; REQ SHALL hold until ack or redirect.
REQ-023 In HOLD: inst_valid=1, with inst_out and inst_pc stable; on inst_ready=1, next state is REQ if en=1, otherwise IDLE.
REQ-024 Any instruction, once accepted, SHALL be presented exactly once; latency from ack to inst_valid SHALL be 1 cycle.
REQ-025 The PC increment SHALL wrap modulo 2^ADDR_W (e.g. all-ones-minus-3 + 4 gives 0), with no overflow flag.
REQ-026 On redirect_valid=1 in any state, pc SHALL load redirect_target with its low log2(STEP) bits cleared.
REQ-027 On redirect, next state SHALL be REQ if en=1, otherwise IDLE, and inst_valid SHALL be 0 in the next cycle.
REQ-028 Redirect SHALL take priority over a simultaneous imem_ack: the acked word is discarded and no instruction is presented.
REQ-029 Redirect SHALL take priority over a simultaneous inst_ready: the held instruction counts as consumed and no new instruction is presented.
REQ-030 imem_addr SHALL equal pc when imem_req=0.

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, inst_pc=RESET_PC, inst_out=0, inst_valid=0 and imem_req=0.
REQ-032 Reset SHALL override redirect, ack and ready in the same cycle.
REQ-033 Reset SHALL abort an in-flight REQ or HOLD, and a late ack arriving after reset SHALL be ignored while in IDLE.

Structure
REQ-034 The FSM state enumeration and the default STEP and RESET_PC constants SHALL reside in the shared package fetch_pkg.
REQ-035 The PC register with increment and redirect logic SHALL be one sub-module, pc_reg, parametrised by ADDR_W, STEP and RESET_PC; the FSM and the instruction hold register SHALL remain in the top module.

Verification
REQ-036 Reset then en=1, memory acks every REQ cycle, inst_ready=1: the bench SHALL see imem_addr 0x0, 0x4, 0x8 and inst_pc following 1 cycle behind each ack.
REQ-037 inst_ready=0 for 3 cycles in HOLD: inst_out and inst_pc SHALL stay constant, with no new imem_req.
REQ-038 redirect_valid=1 with target 0x103 in the same cycle as imem_ack: the word SHALL be dropped, the next imem_addr SHALL be 0x100, and inst_valid SHALL be 0.
REQ-039 With ADDR_W=8, STEP=4, and pc=0xFC acked: pc SHALL become 0x00 and inst_pc SHALL be 0xFC.
REQ-040 Reset asserted while in REQ with ack held high: the next state SHALL be IDLE, pc SHALL equal RESET_PC, and inst_valid SHALL stay 0.
REQ-041 en dropped while in REQ: imem_req SHALL hold until ack, the instruction SHALL be presented, and after inst_ready the FSM SHALL go to IDLE.
